reg_file_write_ctrl: RTL and testbench



---
 rtl/reg_file_write_ctrl_pkg.sv | 20 ++
 rtl/reg_file_write_ctrl_wb.sv | 74 +++++++
 rtl/reg_file_write_ctrl.sv | 142 ++++++++++++++
 tb/tb_reg_file_write_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_write_ctrl_pkg.sv
// Shared register-file writeback definitions.
// Provides the register count / select width constants and the writeback
// request struct (destination select + data) used between the write
// controller and its secondary-source buffer.
package PkgRegisterFile;

  localparam int unsigned NUM_REGS_DEF   = 16;
  localparam int unsigned SEL_WIDTH      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef logic [SEL_WIDTH-1:0] reg_sel_t;

  // Writeback request at the default data width. Instances with a different
  // data width declare the same shape locally and pass it as a type parameter.
  typedef struct packed {
    reg_sel_t                  sel;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_file_write_ctrl_wb.sv
// wb_fifo: small synchronous FIFO for secondary-source writeback requests.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push_i, din_i       enqueue din_i at the tail
//   pop_i, dout_o       dequeue; dout_o always shows the current head
//   count_o             occupancy (0..DEPTH)
//   full_o, empty_o     occupancy decodes
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
module wb_fifo
  import PkgRegisterFile::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = wb_req_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  T                         din_i,
  output T                         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/reg_file_write_ctrl.sv
// reg_file_write_ctrl: register-file write-port arbiter with scoreboard.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   claim_valid, claim_sel          decode marks a destination busy
//   s0_valid, s0_sel, s0_data       primary writeback, always accepted
//   s1_valid, s1_ready, s1_sel,
//   s1_data                         secondary writeback, buffered in a FIFO
//   write_en, write_sel, write_data registered register-file write port
//   busy                            per-register pending-write scoreboard
//   fifo_count                      secondary FIFO occupancy
//   err_unclaimed                   sticky: write issued to a non-busy register
module reg_file_write_ctrl
  import PkgRegisterFile::*;
#(
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          claim_valid,
  input  logic [SEL_WIDTH-1:0]          claim_sel,
  input  logic                          s0_valid,
  input  logic [SEL_WIDTH-1:0]          s0_sel,
  input  logic [DATA_WIDTH-1:0]         s0_data,
  input  logic                          s1_valid,
  output logic                          s1_ready,
  input  logic [SEL_WIDTH-1:0]          s1_sel,
  input  logic [DATA_WIDTH-1:0]         s1_data,
  output logic                          write_en,
  output logic [SEL_WIDTH-1:0]          write_sel,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [NUM_REGS-1:0]           busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_unclaimed
);

  typedef struct packed {
    reg_sel_t              sel;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t                  s1_req, fifo_head;
  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop;

  logic                  issue_valid;
  reg_sel_t              issue_sel;
  logic [DATA_WIDTH-1:0] issue_data;

  logic                  write_en_q,   write_en_d;
  reg_sel_t              write_sel_q,  write_sel_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   busy_q,       busy_d;
  logic                  err_q,        err_d;

  assign s1_req = '{sel: s1_sel, data: s1_data};

  // Ready depends only on FIFO state, never on s0_valid.
  assign s1_ready  = !fifo_full;
  assign fifo_push = s1_valid && s1_ready;
  // s0 has priority; the FIFO head only drains on idle primary cycles.
  assign fifo_pop  = !s0_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (req_t)
  ) u_wb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (s1_req),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    issue_valid = 1'b0;
    issue_sel   = '0;
    issue_data  = '0;
    if (s0_valid) begin
      issue_valid = 1'b1;
      issue_sel   = s0_sel;
      issue_data  = s0_data;
    end else if (fifo_pop) begin
      issue_valid = 1'b1;
      issue_sel   = fifo_head.sel;
      issue_data  = fifo_head.data;
    end
  end

  always_comb begin
    // Register 0 requests consume their slot but never write.
    write_en_d   = issue_valid && (issue_sel != '0);
    write_sel_d  = write_sel_q;
    write_data_d = write_data_q;
    if (issue_valid) begin
      write_sel_d  = issue_sel;
      write_data_d = issue_data;
    end
  end

  // Clear on write first, then set on claim, so a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (write_en_d && (issue_sel == SEL_WIDTH'(r))) begin
        if (!busy_q[r]) err_d = 1'b1;
        busy_d[r] = 1'b0;
      end
      if (claim_valid && (claim_sel == SEL_WIDTH'(r))) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_q   <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      write_en_q   <= write_en_d;
      write_sel_q  <= write_sel_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign write_en      = write_en_q;
  assign write_sel     = write_sel_q;
  assign write_data    = write_data_q;
  assign busy          = busy_q;
  assign err_unclaimed = err_q;

endmodule

// File: tb/tb_reg_file_write_ctrl.sv
module tb_reg_file_write_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        claim_valid;
  logic [3:0]  claim_sel;
  logic        s0_valid;
  logic [3:0]  s0_sel;
  logic [31:0] s0_data;
  logic        s1_valid;
  logic        s1_ready;
  logic [3:0]  s1_sel;
  logic [31:0] s1_data;
  logic        write_en;
  logic [3:0]  write_sel;
  logic [31:0] write_data;
  logic [15:0] busy;
  logic [2:0]  fifo_count;
  logic        err_unclaimed;

  int total = 0;
  int bad   = 0;

  reg_file_write_ctrl #(
    .NUM_REGS   (16),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .claim_valid   (claim_valid),
    .claim_sel     (claim_sel),
    .s0_valid      (s0_valid),
    .s0_sel        (s0_sel),
    .s0_data       (s0_data),
    .s1_valid      (s1_valid),
    .s1_ready      (s1_ready),
    .s1_sel        (s1_sel),
    .s1_data       (s1_data),
    .write_en      (write_en),
    .write_sel     (write_sel),
    .write_data    (write_data),
    .busy          (busy),
    .fifo_count    (fifo_count),
    .err_unclaimed (err_unclaimed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    claim_valid = 1'b0; claim_sel = '0;
    s0_valid = 1'b0; s0_sel = '0; s0_data = '0;
    s1_valid = 1'b0; s1_sel = '0; s1_data = '0;
  endtask

  task automatic claim(input logic [3:0] r);
    claim_valid = 1'b1; claim_sel = r;
    step();
    claim_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    total++; if (write_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", write_en); end
    total++; if (write_sel !== 4'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", write_sel); end
    total++; if (write_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", write_data); end
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL reset_busy got=%h exp=0000", busy); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    total++; if (err_unclaimed !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_unclaimed); end
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", s1_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", s1_ready); end
  endtask

  task automatic test_sole_s0();
    claim(4'd3);
    total++; if (busy !== 16'h0008) begin bad++; $display("FAIL s0_busy_set got=%h exp=0008", busy); end
    s0_valid = 1'b1; s0_sel = 4'd3; s0_data = 32'hDEADBEEF;
    step();
    s0_valid = 1'b0;
    total++; if (write_en !== 1'b1) begin bad++; $display("FAIL s0_we got=%b exp=1", write_en); end
    total++; if (write_sel !== 4'd3) begin bad++; $display("FAIL s0_sel got=%0d exp=3", write_sel); end
    total++; if (write_data !== 32'hDEADBEEF) begin bad++; $display("FAIL s0_data got=%h exp=deadbeef", write_data); end
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL s0_busy_clr got=%h exp=0000", busy); end
    step();
    total++; if (write_en !== 1'b0) begin bad++; $display("FAIL s0_idle_we got=%b exp=0", write_en); end
  endtask

  task automatic test_contention();
    claim(4'd5);
    claim(4'd6);
    s1_valid = 1'b1; s1_sel = 4'd5; s1_data = 32'h11;
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL cont_ready got=%b exp=1", s1_ready); end
    step();
    s1_valid = 1'b0;
    total++; if (write_en !== 1'b0) begin bad++; $display("FAIL cont_nobypass got=%b exp=0", write_en); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL cont_count0 got=%0d exp=1", fifo_count); end
    // r6 re-claimed alongside the first two writes so all three are legitimate.
    for (int i = 0; i < 3; i++) begin
      s0_valid = 1'b1; s0_sel = 4'd6; s0_data = 32'h22;
      claim_valid = (i < 2); claim_sel = 4'd6;
      step();
      total++; if (write_en !== 1'b1 || write_sel !== 4'd6 || write_data !== 32'h22) begin
        bad++; $display("FAIL cont_r6_%0d got=%b/%0d/%h exp=1/6/22", i, write_en, write_sel, write_data); end
      total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL cont_count_%0d got=%0d exp=1", i, fifo_count); end
    end
    claim_valid = 1'b0; s0_valid = 1'b0;
    total++; if (busy !== 16'h0020) begin bad++; $display("FAIL cont_busy got=%h exp=0020", busy); end
    step();
    total++; if (write_en !== 1'b1 || write_sel !== 4'd5 || write_data !== 32'h11) begin
      bad++; $display("FAIL cont_r5 got=%b/%0d/%h exp=1/5/11", write_en, write_sel, write_data); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL cont_count_end got=%0d exp=0", fifo_count); end
    total++; if (busy !== 16'h0000 || err_unclaimed !== 1'b0) begin
      bad++; $display("FAIL cont_end got=%h/%b exp=0000/0", busy, err_unclaimed); end
    step();
  endtask

  task automatic test_fifo_full();
    logic [3:0] sels [5];
    logic [2:0] exp_cnt [5];
    sels = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd9};
    exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 5; k++) claim(sels[k]);
    total++; if (busy !== 16'h0316) begin bad++; $display("FAIL full_claims got=%h exp=0316", busy); end
    // s0 targets register 0: it wins arbitration but never writes.
    s0_valid = 1'b1; s0_sel = 4'd0; s0_data = 32'hAAAA;
    for (int k = 0; k < 5; k++) begin
      s1_valid = 1'b1; s1_sel = sels[k]; s1_data = 32'h100 + k;
      total++; if (s1_ready !== (k < 4)) begin bad++; $display("FAIL full_ready_%0d got=%b exp=%b", k, s1_ready, (k < 4)); end
      step();
      total++; if (write_en !== 1'b0) begin bad++; $display("FAIL full_s0zero_%0d got=%b exp=0", k, write_en); end
    end
    total++; if (fifo_count !== 3'd4 || s1_ready !== 1'b0) begin
      bad++; $display("FAIL full_held got=%0d/%b exp=4/0", fifo_count, s1_ready); end
    s0_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic acc;
      acc = s1_valid && s1_ready;
      step();
      if (acc) s1_valid = 1'b0;
      total++; if (write_en !== 1'b1 || write_sel !== sels[k] || write_data !== 32'h100 + k) begin
        bad++; $display("FAIL full_order_%0d got=%b/%0d/%h exp=1/%0d/%h", k, write_en, write_sel, write_data, sels[k], 32'h100 + k); end
      total++; if (fifo_count !== exp_cnt[k]) begin
        bad++; $display("FAIL full_count_%0d got=%0d exp=%0d", k, fifo_count, exp_cnt[k]); end
    end
    s1_valid = 1'b0;
    total++; if (busy !== 16'h0000 || err_unclaimed !== 1'b0) begin
      bad++; $display("FAIL full_end got=%h/%b exp=0000/0", busy, err_unclaimed); end
    step();
  endtask

  task automatic test_zero_reg();
    claim(4'd0);
    total++; if (busy !== 16'h0000) begin bad++; $display("FAIL zero_claim got=%h exp=0000", busy); end
    s1_valid = 1'b1; s1_sel = 4'd0; s1_data = 32'hFF;
    step();
    s1_valid = 1'b0;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL zero_enq got=%0d exp=1", fifo_count); end
    step();
    total++; if (write_en !== 1'b0 || fifo_count !== 3'd0) begin
      bad++; $display("FAIL zero_pop got=%b/%0d exp=0/0", write_en, fifo_count); end
    total++; if (busy !== 16'h0000 || err_unclaimed !== 1'b0) begin
      bad++; $display("FAIL zero_busy got=%h/%b exp=0000/0", busy, err_unclaimed); end
  endtask

  task automatic test_collision();
    claim(4'd7);
    s0_valid = 1'b1; s0_sel = 4'd7; s0_data = 32'h77;
    claim_valid = 1'b1; claim_sel = 4'd7;
    step();
    claim_valid = 1'b0;
    total++; if (write_en !== 1'b1 || write_sel !== 4'd7) begin
      bad++; $display("FAIL coll_we got=%b/%0d exp=1/7", write_en, write_sel); end
    total++; if (busy !== 16'h0080) begin bad++; $display("FAIL coll_busy got=%h exp=0080", busy); end
    total++; if (err_unclaimed !== 1'b0) begin bad++; $display("FAIL coll_err got=%b exp=0", err_unclaimed); end
    step();
    s0_valid = 1'b0;
    total++; if (busy !== 16'h0000 || err_unclaimed !== 1'b0) begin
      bad++; $display("FAIL coll_clear got=%h/%b exp=0000/0", busy, err_unclaimed); end
  endtask

  task automatic test_err_sticky();
    s0_valid = 1'b1; s0_sel = 4'd2; s0_data = 32'h2;
    step();
    s0_valid = 1'b0;
    total++; if (err_unclaimed !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err_unclaimed); end
    step(); step();
    total++; if (err_unclaimed !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_unclaimed); end
  endtask

  task automatic test_reset_mid();
    claim(4'd11); claim(4'd12); claim(4'd13); claim(4'd14);
    for (int k = 0; k < 3; k++) begin
      s0_valid = 1'b1; s0_sel = 4'd14; s0_data = 32'hE0 + k;
      claim_valid = 1'b1; claim_sel = 4'd14;
      s1_valid = 1'b1; s1_sel = 4'd11 + k; s1_data = 32'hB0 + k;
      step();
    end
    idle_inputs();
    total++; if (fifo_count !== 3'd3 || write_en !== 1'b1) begin
      bad++; $display("FAIL rmid_pre got=%0d/%b exp=3/1", fifo_count, write_en); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (write_en !== 1'b0 || write_sel !== 4'd0 || write_data !== 32'd0) begin
      bad++; $display("FAIL rmid_out got=%b/%0d/%h exp=0/0/0", write_en, write_sel, write_data); end
    total++; if (fifo_count !== 3'd0 || busy !== 16'h0000 || err_unclaimed !== 1'b0 || s1_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_state got=%0d/%h/%b/%b exp=0/0000/0/1", fifo_count, busy, err_unclaimed, s1_ready); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (write_en !== 1'b0 || fifo_count !== 3'd0) begin
        bad++; $display("FAIL rmid_after_%0d got=%b/%0d exp=0/0", k, write_en, fifo_count); end
    end
  endtask

  initial begin
    test_reset();
    test_sole_s0();
    test_contention();
    test_fifo_full();
    test_zero_reg();
    test_collision();
    test_err_sticky();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
